fifo_sync_param: RTL and testbench
==================================

# fifo_sync_param

Parametrised single-clock FIFO, the next generation of the team's FIFO building block for the verification labs. It generalises data width and depth and adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It serves as a standalone buffer in single-domain datapaths and as the DUT for the parametrised FIFO testbench.

## Interface
Parameters:
- DATA_W, 8, width of data_in/data_out in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=4.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
- FWFT, 0, 0 = registered read, 1 = first-word-fall-through.
- Illegal combinations are elaboration errors: DEPTH not a power of two, DEPTH<4, or not (1 <= AE_LEVEL < AF_LEVEL <= DEPTH).

Ports (AW = $clog2(DEPTH)):
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  DATA_W  write data, sampled on an accepted push.
- push  input  1  write request.
- full  output  1  count == DEPTH.
- almost_full  output  1  count >= AF_LEVEL.
- data_out  output  DATA_W  read data (see Operation).
- pop  input  1  read request.
- empty  output  1  count == 0.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; a push was attempted while full.
- underflow  output  1  sticky; a pop was attempted while empty.
- err_clr  input  1  synchronous clear of overflow/underflow.

## Operation
- Storage: DEPTH x DATA_W array, not reset. Write and read pointers are AW+1 bits wide; the address is the low AW bits and wrap-around is natural modulo 2^(AW+1). count = wr_ptr - rd_ptr (AW+1 bits).
- Push accepted iff push && !full, using the registered full. A pop in the same cycle does not make room; push while full is always rejected.
- Pop accepted iff pop && !empty, using the registered empty. A same-cycle push gives no bypass; pop while empty is always rejected.
- Simultaneous accepted push and pop: both pointers advance and count is unchanged.
- full, empty, almost_full and almost_empty are decoded from registered pointers/count only. They never depend combinationally on push or pop.
- FWFT=0: data_out is a register. On an accepted pop it loads mem[rd_addr] and holds otherwise. Reset value is 0.
- FWFT=1: data_out = mem[rd_addr] combinationally. It is valid whenever empty==0 and must not be checked while empty==1. An accepted pop advances the pointer, so the next word appears the following cycle.
- Rejected push/pop change no pointer, memory or data_out state.
- overflow is set by push && full; underflow is set by pop && empty. Both stay set until err_clr. If err_clr and a new error occur in the same cycle, set wins.

## Timing
- Reset (async assert, sync release at the next clock edge) forces: pointers and count 0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, data_out=0 (FWFT=0). Memory contents are kept but are unreachable.
- Reset asserted mid-operation discards all stored entries immediately. The first push after release is written to address 0.
- Push latency: after an accepted push at edge N, count, empty, almost_* and full reflect it after edge N.
- FWFT=0 read latency: data_out holds the popped word 1 cycle after the pop edge.
- FWFT=1 read latency: a word pushed at edge N is on data_out after edge N (empty deasserts at the same moment).
- Error flags assert 1 cycle after the offending request edge.

## Test plan
- Reset/idle: assert reset mid-stream with count=5 -> count=0, empty=1, almost_empty=1, full=0, overflow=0, data_out=0 immediately. After release, push 0xA5 and pop -> 0xA5 returned.
- Fill/drain, defaults, FWFT=0: push 0x00..0x0F -> full=1 after the 16th push, almost_full=1 after the 14th (count=14). Pop 16 -> data_out sequence 0x00..0x0F, each 1 cycle after its pop; empty=1 after the 16th pop; almost_empty=1 from count=2.
- Wrap-around: run 40 push/pop pairs at count=3 -> pointers wrap twice, data order preserved, count stays 3.
- Simultaneous at boundaries: full, push+pop -> push rejected, count=15, overflow=1. Empty, push+pop -> pop rejected, count=1, underflow=1.
- Error flags: with overflow=1, err_clr alone -> overflow=0 next cycle. err_clr together with a push while full -> overflow stays 1.
- FWFT=1, DATA_W=32, DEPTH=8: push 0xDEADBEEF -> data_out=0xDEADBEEF while empty=0, before any pop. Pop -> the next word appears 1 cycle later.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags,
// sticky overflow/underflow and selectable first-word-fall-through reads.
module fifo_sync_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter bit          FWFT     = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     push,
    output logic                     full,
    output logic                     almost_full,
    output logic [DATA_W-1:0]        data_out,
    input  logic                     pop,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 4)) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of two >= 4");
    end
    if (!((AE_LEVEL >= 1) && (AE_LEVEL < AF_LEVEL)
          && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
        $error("fifo_sync_param: need 1 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              push_ok, pop_ok;
    logic [AW-1:0]     rd_addr;

    // All status decodes come from registered pointers only.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_addr = rd_ptr_q[AW-1:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + ONE_C;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE_C;
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        // A fresh error in the clearing cycle must not be lost.
        if (push && full) ovf_d = 1'b1;
        if (pop && empty) udf_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
    end

    if (FWFT) begin : g_fwft
        assign data_out = mem_q[rd_addr];
    end else begin : g_reg
        logic [DATA_W-1:0] dout_q;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                dout_q <= '0;
            end else if (pop_ok) begin
                dout_q <= mem_q[rd_addr];
            end
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised scoreboard bench: a registered-read FIFO (defaults) and a
// 32x8 first-word-fall-through FIFO, both checked against queue models.
module tb_fifo_sync_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic [7:0]  din1, dout1;
    logic        push1, pop1, clr1;
    logic        full1, af1, empty1, ae1, ovf1, udf1;
    logic [4:0]  cnt1;

    logic [31:0] din2, dout2;
    logic        push2, pop2, clr2;
    logic        full2, af2, empty2, ae2, ovf2, udf2;
    logic [3:0]  cnt2;

    fifo_sync_param u_dut1 (
        .clock(clock), .reset(reset),
        .data_in(din1), .push(push1),
        .full(full1), .almost_full(af1),
        .data_out(dout1), .pop(pop1),
        .empty(empty1), .almost_empty(ae1),
        .count(cnt1), .overflow(ovf1),
        .underflow(udf1), .err_clr(clr1)
    );

    fifo_sync_param #(
        .DATA_W(32), .DEPTH(8), .FWFT(1'b1)
    ) u_dut2 (
        .clock(clock), .reset(reset),
        .data_in(din2), .push(push2),
        .full(full2), .almost_full(af2),
        .data_out(dout2), .pop(pop2),
        .empty(empty2), .almost_empty(ae2),
        .count(cnt2), .overflow(ovf2),
        .underflow(udf2), .err_clr(clr2)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  m1[$];
    logic [7:0]  e1[$];
    logic [7:0]  hold1 = 8'h00;
    bit          mo1, mu1;
    logic [31:0] m2[$];
    bit          mo2, mu2;
    bit          mon_en = 1'b0;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    task automatic step1(bit ps, bit pp, logic [7:0] d, bit ec);
        bit wok, pok;
        push1 = ps; pop1 = pp; din1 = d; clr1 = ec;
        @(posedge clock);
        wok = ps && (m1.size() < 16);
        pok = pp && (m1.size() > 0);
        if (ps && m1.size() == 16) mo1 = 1'b1;
        else if (ec) mo1 = 1'b0;
        if (pp && m1.size() == 0) mu1 = 1'b1;
        else if (ec) mu1 = 1'b0;
        if (pok) e1.push_back(m1.pop_front());
        if (wok) m1.push_back(d);
        #1;
        push1 = 1'b0; pop1 = 1'b0; clr1 = 1'b0;
    endtask

    task automatic step2(bit ps, bit pp, logic [31:0] d, bit ec);
        bit wok, pok;
        push2 = ps; pop2 = pp; din2 = d; clr2 = ec;
        @(posedge clock);
        wok = ps && (m2.size() < 8);
        pok = pp && (m2.size() > 0);
        if (ps && m2.size() == 8) mo2 = 1'b1;
        else if (ec) mo2 = 1'b0;
        if (pp && m2.size() == 0) mu2 = 1'b1;
        else if (ec) mu2 = 1'b0;
        if (pok) void'(m2.pop_front());
        if (wok) m2.push_back(d);
        #1;
        push2 = 1'b0; pop2 = 1'b0; clr2 = 1'b0;
    endtask

    // Monitor: compares every DUT output to the models on the falling edge.
    always @(negedge clock) begin
        if (!reset) begin
            hold1 = 8'h00;
        end else if (mon_en) begin
            if (e1.size() > 0) hold1 = e1.pop_front();
            chk("dout1", 32'(dout1), 32'(hold1));
            chk("cnt1", 32'(cnt1), m1.size());
            chk("empty1", 32'(empty1), 32'(m1.size() == 0));
            chk("full1", 32'(full1), 32'(m1.size() == 16));
            chk("af1", 32'(af1), 32'(m1.size() >= 14));
            chk("ae1", 32'(ae1), 32'(m1.size() <= 2));
            chk("ovf1", 32'(ovf1), 32'(mo1));
            chk("udf1", 32'(udf1), 32'(mu1));
            chk("cnt2", 32'(cnt2), m2.size());
            chk("empty2", 32'(empty2), 32'(m2.size() == 0));
            chk("full2", 32'(full2), 32'(m2.size() == 8));
            chk("af2", 32'(af2), 32'(m2.size() >= 6));
            chk("ae2", 32'(ae2), 32'(m2.size() <= 2));
            chk("ovf2", 32'(ovf2), 32'(mo2));
            chk("udf2", 32'(udf2), 32'(mu2));
            if (m2.size() > 0) chk("dout2", dout2, m2[0]);
        end
    end

    initial begin
        reset = 1'b0;
        push1 = 1'b0; pop1 = 1'b0; clr1 = 1'b0; din1 = '0;
        push2 = 1'b0; pop2 = 1'b0; clr2 = 1'b0; din2 = '0;
        mo1 = 1'b0; mu1 = 1'b0; mo2 = 1'b0; mu2 = 1'b0;
        #12;
        chk("rst_cnt", 32'(cnt1), 32'd0);
        chk("rst_empty", 32'(empty1), 32'd1);
        chk("rst_ae", 32'(ae1), 32'd1);
        chk("rst_full", 32'(full1), 32'd0);
        chk("rst_dout", 32'(dout1), 32'd0);
        chk("rst_cnt2", 32'(cnt2), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        mon_en = 1'b1;

        // Reset mid-stream with five entries stored
        for (int i = 0; i < 5; i++) step1(1'b1, 1'b0, 8'(i + 8'h30), 1'b0);
        step1(1'b0, 1'b1, 8'h00, 1'b0);
        chk("pre_rst_cnt", 32'(cnt1), 32'd4);
        step1(1'b1, 1'b0, 8'h77, 1'b0);
        chk("pre_rst_cnt5", 32'(cnt1), 32'd5);
        reset = 1'b0;
        #1;
        m1.delete(); e1.delete(); mo1 = 1'b0; mu1 = 1'b0;
        chk("mid_rst_cnt", 32'(cnt1), 32'd0);
        chk("mid_rst_empty", 32'(empty1), 32'd1);
        chk("mid_rst_ae", 32'(ae1), 32'd1);
        chk("mid_rst_full", 32'(full1), 32'd0);
        chk("mid_rst_ovf", 32'(ovf1), 32'd0);
        chk("mid_rst_dout", 32'(dout1), 32'd0);
        @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        step1(1'b1, 1'b0, 8'hA5, 1'b0);
        step1(1'b0, 1'b1, 8'h00, 1'b0);
        chk("a5_dout", 32'(dout1), 32'hA5);

        // Fill and drain
        for (int i = 0; i < 16; i++) begin
            step1(1'b1, 1'b0, 8'(i), 1'b0);
            if (i == 13) chk("af_at14", 32'(af1), 32'd1);
            if (i == 14) chk("nfull_at15", 32'(full1), 32'd0);
        end
        chk("full_at16", 32'(full1), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step1(1'b0, 1'b1, 8'h00, 1'b0);
            chk("drain_dout", 32'(dout1), 32'(i));
        end
        chk("drain_empty", 32'(empty1), 32'd1);

        // Pointer wrap-around at count 3
        for (int i = 0; i < 3; i++) step1(1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) step1(1'b1, 1'b1, 8'($urandom), 1'b0);
        chk("wrap_cnt", 32'(cnt1), 32'd3);
        for (int i = 0; i < 3; i++) step1(1'b0, 1'b1, 8'h00, 1'b0);

        // Simultaneous push+pop at full and at empty
        for (int i = 0; i < 16; i++) step1(1'b1, 1'b0, 8'($urandom), 1'b0);
        step1(1'b1, 1'b1, 8'hEE, 1'b0);
        chk("full_pp_cnt", 32'(cnt1), 32'd15);
        chk("full_pp_ovf", 32'(ovf1), 32'd1);
        for (int i = 0; i < 15; i++) step1(1'b0, 1'b1, 8'h00, 1'b0);
        step1(1'b1, 1'b1, 8'h5C, 1'b0);
        chk("empty_pp_cnt", 32'(cnt1), 32'd1);
        chk("empty_pp_udf", 32'(udf1), 32'd1);

        // Error flag clearing, and set-wins against a same-cycle clear
        step1(1'b0, 1'b0, 8'h00, 1'b1);
        chk("clr_ovf", 32'(ovf1), 32'd0);
        chk("clr_udf", 32'(udf1), 32'd0);
        for (int i = 0; i < 15; i++) step1(1'b1, 1'b0, 8'($urandom), 1'b0);
        step1(1'b1, 1'b0, 8'h99, 1'b1);
        chk("clr_vs_set", 32'(ovf1), 32'd1);
        for (int i = 0; i < 16; i++) step1(1'b0, 1'b1, 8'h00, 1'b0);
        step1(1'b0, 1'b0, 8'h00, 1'b1);

        // Random traffic on the registered-read FIFO
        for (int i = 0; i < 400; i++) begin
            step1($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                  8'($urandom), $urandom_range(0, 99) < 5);
        end

        // First-word-fall-through instance
        step2(1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
        chk("fwft_first", dout2, 32'hDEADBEEF);
        chk("fwft_nempty", 32'(empty2), 32'd0);
        step2(1'b1, 1'b0, 32'h12345678, 1'b0);
        chk("fwft_hold", dout2, 32'hDEADBEEF);
        step2(1'b0, 1'b1, 32'h0, 1'b0);
        chk("fwft_next", dout2, 32'h12345678);
        for (int i = 0; i < 300; i++) begin
            step2($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                  $urandom, $urandom_range(0, 99) < 5);
        end
        for (int i = 0; i < 10; i++) step2(1'b0, 1'b1, 32'h0, 1'b0);
        chk("fwft_drained", 32'(empty2), 32'd1);

        @(negedge clock);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
